// File: rtl/output_pkg.sv
// output_pkg: shared state, beat-code and framing definitions for the output scheduler.
package output_pkg;
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, GAP} sched_state_t;
    localparam logic [1:0] BEAT_IDLE = 2'b00;
    localparam logic [1:0] BEAT_HDR  = 2'b10;
    localparam logic [1:0] BEAT_DATA = 2'b11;
    localparam logic [3:0] HDR_TAG   = 4'hA;
    function automatic logic [9:0] beat_word(sched_state_t st, logic [3:0] id, logic [15:0] dat);
        return st == HDR ? {HDR_TAG, id, BEAT_HDR} :
               st == HI  ? {dat[15:8], BEAT_DATA} :
               st == LO  ? {dat[7:0], BEAT_DATA} : {8'd0, BEAT_IDLE};
    endfunction
endpackage

// File: rtl/output_sched_if.sv
// output_sched_if: producer-side request/data bundle plus the framed output bus.
interface output_sched_if #(parameter int NUM_SRC = 4);
    logic [NUM_SRC-1:0]    req;
    logic [16*NUM_SRC-1:0] data;
    logic                  hold;
    logic [NUM_SRC-1:0]    ack;
    logic [9:0]            out;
    logic                  busy;
    modport master (output req, data, hold, input ack, out, busy);
    modport slave  (input req, data, hold, output ack, out, busy);
endinterface

// File: rtl/output_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx
);
    logic [IW-1:0] idx;
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        idx = '0;
        // walk farthest-first so the nearest requester after last wins
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % NUM_SRC);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx = idx;
            end
        end
    end
endmodule

// File: rtl/output_sched.sv
// output_sched: grants one producer at a time and emits a header/high/low frame on out,
// followed by GAP_CYCLES idle beats.
module output_sched
    import output_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 1
) (
    input logic         clock,
    input logic         reset_n,
    output_sched_if.slave bus
);
    localparam int IW = $clog2(NUM_SRC);
    sched_state_t       state_q, state_d;
    logic [IW-1:0]      last_q, last_d, id_q, id_d, grant_idx;
    logic [15:0]        hold_q, hold_d;
    logic [2:0]         gap_q, gap_d;
    logic [9:0]         out_q, out_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               busy_q, busy_d, grant_valid;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req(bus.req), .last(last_q), .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d = last_q;
        id_d = id_q;
        hold_d = hold_q;
        gap_d = gap_q;
        ack_d = '0;
        case (state_q)
            IDLE: if (grant_valid) begin
                state_d = HDR;
                last_d = grant_idx;
                id_d = grant_idx;
                hold_d = bus.data[16*grant_idx +: 16];
                ack_d[grant_idx] = 1'b1;
            end
            HDR: state_d = bus.hold ? HDR : HI;
            HI:  state_d = bus.hold ? HI : LO;
            LO: if (!bus.hold) begin
                state_d = GAP_CYCLES == 0 ? IDLE : GAP;
                gap_d = 3'(GAP_CYCLES - 1);
            end
            GAP: if (!bus.hold) begin
                state_d = gap_q == 3'd0 ? IDLE : GAP;
                gap_d = gap_q == 3'd0 ? gap_q : gap_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        // outputs are precomputed from next state so every port comes straight off a flop
        out_d = beat_word(state_d, 4'(id_d), hold_d);
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q <= IW'(NUM_SRC - 1);
            id_q <= '0;
            hold_q <= '0;
            gap_q <= '0;
            out_q <= '0;
            ack_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            hold_q <= hold_d;
            gap_q <= gap_d;
            out_q <= out_d;
            ack_q <= ack_d;
            busy_q <= busy_d;
        end
    end

    assign bus.ack = ack_q;
    assign bus.out = out_q;
    assign bus.busy = busy_q;
endmodule
